fp_normalize: RTL and testbench

FP_NORMALIZE -- requirements
Module: fp_normalize

---
 rtl/fp_normalize.sv | 94 +++++++++
 tb/tb_fp_normalize.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/fp_normalize.sv
// Normalizer front end: turns a 12-bit two's-complement sample into an unrounded
// sign / 3-bit exponent / 4-bit significand / guard bit by left-shifting one bit per cycle.
module fp_normalize (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [11:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        sign,
    output logic [2:0]  exp,
    output logic [3:0]  sig,
    output logic        fifth_bit
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [10:0] w;
    logic [2:0]  cnt;
    logic [10:0] mag;
    logic        finish;

    // -2048 has no 11-bit magnitude, so it saturates to the largest one.
    always_comb begin
        mag = in_data[10:0];
        if (in_data[11]) begin
            if (in_data[10:0] == 11'd0)
                mag = 11'h7FF;
            else
                mag = ~in_data[10:0] + 11'd1;
        end
    end

    assign finish    = w[10] || (cnt == 3'd0);
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)  state_next = SHIFT;
            SHIFT:   if (finish)    state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sign      <= 1'b0;
            exp       <= 3'd0;
            sig       <= 4'd0;
            fifth_bit <= 1'b0;
            w         <= 11'd0;
            cnt       <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sign <= in_data[11];
                        w    <= mag;
                        cnt  <= 3'd7;
                    end
                end
                SHIFT: begin
                    if (finish) begin
                        exp       <= cnt;
                        sig       <= w[10:7];
                        fifth_bit <= w[6];
                    end else begin
                        w   <= {w[9:0], 1'b0};
                        cnt <= cnt - 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_normalize.sv
// Self-checking bench for fp_normalize: directed corner cases plus random samples
// compared against an arithmetic leading-zero model.
module tb_fp_normalize;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic        sign;
    logic [2:0]  exp;
    logic [3:0]  sig;
    logic        fifth_bit;

    int checks = 0;
    int errors = 0;

    fp_normalize dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sign      (sign),
        .exp       (exp),
        .sig       (sig),
        .fifth_bit (fifth_bit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    // Reference: exponent from the leading-zero count of the 12-bit magnitude.
    task automatic modelNormalize(input logic [11:0] d, output int m_sign, output int m_exp,
                                  output int m_sig, output int m_fifth, output int m_lat);
        int value;
        int mag;
        int k;
        int s;
        bit found;
        value = (d[11]) ? int'(d) - 4096 : int'(d);
        mag   = (value < 0) ? -value : value;
        if (mag > 2047) mag = 2047;
        k = 12;
        found = 1'b0;
        for (int i = 11; i >= 0; i--) begin
            if (!found && ((mag >> i) & 1) == 1) begin
                k = 11 - i;
                found = 1'b1;
            end
        end
        m_exp   = (k >= 1 && k <= 7) ? 8 - k : 0;
        s       = 7 - m_exp;
        m_sig   = ((mag << s) >> 7) & 15;
        m_fifth = ((mag << s) >> 6) & 1;
        m_sign  = int'(d[11]);
        m_lat   = 1 + s;
    endtask

    task automatic waitResult(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic applyStimulus(input logic [11:0] d, input logic ready_early);
        int m_sign, m_exp, m_sig, m_fifth, m_lat, lat;
        modelNormalize(d, m_sign, m_exp, m_sig, m_fifth, m_lat);
        checkOutput("in_ready_idle", 32'(in_ready), 32'd1);
        in_data   = d;
        in_valid  = 1'b1;
        out_ready = ready_early;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        waitResult(lat);
        checkOutput("latency", 32'(lat), 32'(m_lat));
        checkOutput("sign", 32'(sign), 32'(m_sign));
        checkOutput("exp", 32'(exp), 32'(m_exp));
        checkOutput("sig", 32'(sig), 32'(m_sig));
        checkOutput("fifth_bit", 32'(fifth_bit), 32'(m_fifth));
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("out_valid_drop", 32'(out_valid), 32'd0);
        checkOutput("in_ready_back", 32'(in_ready), 32'd1);
        out_ready = 1'b0;
    endtask

    initial begin
        int lat;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 12'd0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_outputs", {23'd0, sign, exp, sig, fifth_bit}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("in_ready_after_rst", 32'(in_ready), 32'd1);

        $display("[TB] directed corner cases");
        applyStimulus(12'h000, 1'b0);
        applyStimulus(12'd422, 1'b0);
        applyStimulus(12'h800, 1'b0);
        applyStimulus(12'hFFF, 1'b0);
        applyStimulus(12'h7FF, 1'b1);
        applyStimulus(12'h801, 1'b1);

        $display("[TB] back-pressure with ignored second sample");
        in_data  = 12'd46;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_data = 12'h001;
        lat = 0;
        while (!out_valid && lat < 20) begin
            checkOutput("stall_in_ready_shift", 32'(in_ready), 32'd0);
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput("stall_latency", 32'(lat), 32'd6);
        for (int i = 0; i < 5; i++) begin
            checkOutput("stall_in_ready_done", 32'(in_ready), 32'd0);
            checkOutput("stall_out_valid", 32'(out_valid), 32'd1);
            checkOutput("stall_hold", {23'd0, sign, exp, sig, fifth_bit}, {23'd0, 1'b0, 3'd2, 4'b1011, 1'b1});
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkOutput("stall_idle", 32'(in_ready), 32'd1);
        checkOutput("stall_out_drop", 32'(out_valid), 32'd0);
        repeat (10) @(posedge clk);
        #1;
        checkOutput("stall_not_consumed", 32'(out_valid), 32'd0);

        $display("[TB] reset mid-shift");
        in_data  = 12'h001;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("pre_rst_busy", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("midrst_outputs", {23'd0, sign, exp, sig, fifth_bit}, 32'd0);
        @(posedge clk);
        #1;
        checkOutput("midrst_in_ready", 32'(in_ready), 32'd1);
        lat = 0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid) lat++;
            @(posedge clk);
            #1;
        end
        checkOutput("midrst_no_pulse", 32'(lat), 32'd0);

        $display("[TB] random samples");
        for (int i = 0; i < 60; i++) begin
            applyStimulus(12'($urandom_range(0, 4095)), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
